// File: rtl/serv_sleep_ctrl.sv
// WFI sleep/wake sequencer: stalls the core, drains ibus/dbus, handshakes low power
// with the clock unit and holds the core off for a settling delay after lp_ack falls.
module serv_sleep_ctrl #(
  parameter int WAKE_DELAY    = 4,
  parameter int DRAIN_TIMEOUT = 15,
  parameter int CNT_W         = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_sleep_req,
  input  logic        i_wakeup_req,
  input  logic        i_ibus_busy,
  input  logic        i_dbus_busy,
  input  logic        i_lp_ack,
  output logic        o_core_en,
  output logic        o_lp_req,
  output logic        o_sleeping,
  output logic        o_drain_to,
  output logic [15:0] o_sleep_cycles
);

  typedef enum logic [1:0] {RUN, DRAIN, SLEEP, WAKE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] WD_C    = CNT_W'(WAKE_DELAY);
  localparam logic [CNT_W-1:0] DT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             bus_idle;

  assign bus_idle = ~i_ibus_busy & ~i_dbus_busy;

  // Level outputs are registered from the current state, so they trail it by one edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= RUN;
      cnt            <= '0;
      o_core_en      <= 1'b1;
      o_lp_req       <= 1'b0;
      o_sleeping     <= 1'b0;
      o_drain_to     <= 1'b0;
      o_sleep_cycles <= '0;
    end else begin
      o_core_en  <= (state == RUN);
      o_lp_req   <= (state == SLEEP);
      o_sleeping <= (state == SLEEP) || (state == WAKE);
      o_drain_to <= 1'b0;
      case (state)
        RUN: begin
          if (i_sleep_req && !i_wakeup_req) begin
            state <= DRAIN;
            cnt   <= '0;
          end
        end
        DRAIN: begin
          if (i_wakeup_req) begin
            state <= RUN;
          end else if (bus_idle) begin
            state          <= SLEEP;
            o_sleep_cycles <= '0;
          end else if ((DRAIN_TIMEOUT != 0) && (cnt == DT_LAST)) begin
            state      <= RUN;
            o_drain_to <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        SLEEP: begin
          if (o_sleep_cycles != 16'hFFFF) o_sleep_cycles <= o_sleep_cycles + 16'd1;
          if (i_wakeup_req) begin
            state <= WAKE;
            cnt   <= '0;
          end
        end
        WAKE: begin
          // Settling delay only counts once the clock unit has left low power.
          if (!i_lp_ack) begin
            if (cnt >= WD_C)        state <= RUN;
            else if (cnt != CNT_MAX) cnt  <= cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_sleep_ctrl.sv
// Randomised episode bench for serv_sleep_ctrl: each sleep attempt predicts a summary
// record (stall length, lp/sleeping cycles, timeout pulses, sleep counter) from timing rules.
module tb_serv_sleep_ctrl;
  localparam int WD = 4;
  localparam int DT = 15;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_sleep_req = 1'b0, i_wakeup_req = 1'b0;
  logic        i_ibus_busy = 1'b0, i_dbus_busy = 1'b0;
  logic        i_lp_ack;
  logic        o_core_en, o_lp_req, o_sleeping, o_drain_to;
  logic [15:0] o_sleep_cycles;

  serv_sleep_ctrl #(.WAKE_DELAY(WD), .DRAIN_TIMEOUT(DT), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sleep_req(i_sleep_req), .i_wakeup_req(i_wakeup_req),
    .i_ibus_busy(i_ibus_busy), .i_dbus_busy(i_dbus_busy), .i_lp_ack(i_lp_ack),
    .o_core_en(o_core_en), .o_lp_req(o_lp_req), .o_sleeping(o_sleeping),
    .o_drain_to(o_drain_to), .o_sleep_cycles(o_sleep_cycles));

  always #5 i_clk = ~i_clk;

  // Clock unit: lp_ack seen at edge t equals lp_req as it stood after edge t-1-ack_dly.
  int         ack_dly = 1;
  logic [3:0] ack_sh;
  always @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) ack_sh <= '0;
    else          ack_sh <= {ack_sh[2:0], o_lp_req};
  always_comb begin
    i_lp_ack = o_lp_req;
    case (ack_dly)
      1: i_lp_ack = ack_sh[0];
      2: i_lp_ack = ack_sh[1];
      3: i_lp_ack = ack_sh[2];
      default: i_lp_ack = o_lp_req;
    endcase
  end

  typedef struct {int low; int lp; int slp; int dto; int sc;} ep_t;
  ep_t exp_q[$];
  int  n_chk = 0, n_err = 0;
  int  prev_sc = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Monitor: an episode is a run of samples with core_en low; lp/sleeping/timeout
  // samples are accumulated since the previous episode so stray assertions show up too.
  int m_low = 0, m_lp = 0, m_slp = 0, m_dto = 0;
  bit in_ep = 1'b0;
  ep_t m_e;
  initial forever begin
    @(posedge i_clk); #1;
    if (!i_rst_n) begin
      m_low = 0; m_lp = 0; m_slp = 0; m_dto = 0; in_ep = 1'b0;
    end else begin
      m_lp  += int'(o_lp_req);
      m_slp += int'(o_sleeping);
      m_dto += int'(o_drain_to);
      if (!o_core_en) begin
        in_ep = 1'b1;
        m_low++;
      end else if (in_ep) begin
        in_ep = 1'b0;
        if (exp_q.size() == 0) chk("unexpected_episode", 1, 0);
        else begin
          m_e = exp_q.pop_front();
          chk("stall_cycles",   m_low, m_e.low);
          chk("lp_req_cycles",  m_lp,  m_e.lp);
          chk("sleeping_cycles", m_slp, m_e.slp);
          chk("drain_to_pulses", m_dto, m_e.dto);
          chk("sleep_cycles",   int'(o_sleep_cycles), m_e.sc);
        end
        m_low = 0; m_lp = 0; m_slp = 0; m_dto = 0;
      end
    end
  end

  // b: cycles a bus stays busy after the request; s: cycles in SLEEP;
  // k>0: wakeup first seen on the k-th edge after the request (during DRAIN).
  task automatic run_ep(input int b, input int s, input int k);
    ep_t e;
    if (k > 0)        e = '{k, 0, 0, 0, prev_sc};
    else if (b >= DT) e = '{DT, 0, 0, 1, prev_sc};
    else begin
      e = '{b + s + ack_dly + 3 + WD, s, s + ack_dly + 2 + WD, 0, (s > 65535) ? 65535 : s};
      prev_sc = e.sc;
    end
    exp_q.push_back(e);
    i_sleep_req = 1'b1;
    if (b > 0) begin
      if ($urandom_range(0, 1) == 0) i_ibus_busy = 1'b1; else i_dbus_busy = 1'b1;
    end
    @(negedge i_clk);
    i_sleep_req = 1'b0;
    for (int j = 1; j <= b; j++) begin
      if (j == k) i_wakeup_req = 1'b1;
      @(negedge i_clk);
    end
    i_ibus_busy = 1'b0;
    i_dbus_busy = 1'b0;
    if (k > 0 || b >= DT) begin
      if (k == b + 1) i_wakeup_req = 1'b1;
      @(negedge i_clk);
      i_wakeup_req = 1'b0;
      repeat (4) @(negedge i_clk);
    end else begin
      for (int j = 0; j < s; j++) begin
        i_sleep_req = (j == 1);
        @(negedge i_clk);
      end
      i_sleep_req  = 1'b0;
      i_wakeup_req = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge i_clk);
      i_wakeup_req = 1'b0;
      repeat (ack_dly + WD + 6) @(negedge i_clk);
    end
  endtask

  task automatic run_nop();
    i_sleep_req  = 1'b1;
    i_wakeup_req = 1'b1;
    @(negedge i_clk);
    i_sleep_req  = 1'b0;
    i_wakeup_req = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("nop_core_en", int'(o_core_en), 1);
  endtask

  // Enter SLEEP (and optionally WAKE) then pull reset between edges.
  task automatic reset_mid(input bit in_wake);
    i_sleep_req = 1'b1;
    @(negedge i_clk);
    i_sleep_req = 1'b0;
    repeat (6) @(negedge i_clk);
    if (in_wake) begin
      i_wakeup_req = 1'b1;
      @(negedge i_clk);
      i_wakeup_req = 1'b0;
      @(negedge i_clk);
    end
    chk("pre_rst_core_en", int'(o_core_en), 0);
    chk("pre_rst_lp_req",  int'(o_lp_req), in_wake ? 0 : 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_core_en",  int'(o_core_en), 1);
    chk("rst_lp_req",   int'(o_lp_req), 0);
    chk("rst_sleeping", int'(o_sleeping), 0);
    chk("rst_sleep_cycles", int'(o_sleep_cycles), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    prev_sc = 0;
    repeat (6) @(negedge i_clk);
  endtask

  initial begin
    int b;
    #1 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("reset_core_en",      int'(o_core_en), 1);
    chk("reset_lp_req",       int'(o_lp_req), 0);
    chk("reset_sleeping",     int'(o_sleeping), 0);
    chk("reset_drain_to",     int'(o_drain_to), 0);
    chk("reset_sleep_cycles", int'(o_sleep_cycles), 0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    ack_dly = 1;
    run_ep(0, 10, 0);   // plain sleep/wake
    run_nop();          // WFI with wakeup pending
    run_ep(20, 0, 0);   // drain timeout
    run_ep(3, 0, 2);    // wakeup during drain
    run_ep(14, 5, 0);   // drains on the last allowed cycle
    run_ep(15, 0, 0);   // times out on the first disallowed cycle
    run_ep(5, 0, 6);    // wakeup on the same edge the busses go idle

    for (int i = 0; i < 30; i++) begin
      ack_dly = int'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: run_nop();
        1: begin b = int'($urandom_range(1, 14)); run_ep(b, 0, int'($urandom_range(1, b + 1))); end
        2: run_ep(int'($urandom_range(15, 22)), 0, 0);
        default: run_ep(int'($urandom_range(0, 14)), int'($urandom_range(4, 30)), 0);
      endcase
    end

    ack_dly = 2;
    run_ep(0, 70000, 0);  // sleep counter saturates and holds
    run_ep(16, 0, 0);     // saturated count survives a timed-out attempt

    ack_dly = 3;
    reset_mid(1'b1);
    reset_mid(1'b0);
    ack_dly = 1;
    run_ep(0, 6, 0);

    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !in_ep) break;
      @(negedge i_clk);
    end
    chk("episodes_outstanding", exp_q.size(), 0);
    chk("episode_open", int'(in_ep), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
